// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: one outstanding imem request, fetch output register plus skid.
// Define FETCH_PERF_EN to add the perf_bubbles / perf_squash counters.
`ifndef WORDSIZE
`define WORDSIZE 64
`endif

module fetch_sequencer #(
  parameter int AW = `WORDSIZE,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  output logic          pc_stall,
  output logic          pc_branch,
  output logic [AW-1:0] pc_branchpc,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          hazard_stall,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  output logic          if_valid,
  output logic [AW-1:0] if_pc,
  output logic [IW-1:0] if_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_bubbles,
  output logic [31:0]   perf_squash
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } fetch_t;

  state_t state;
  logic   squash;
  fetch_t out_q, skid_q;

  logic consume, out_free, rsp, drop, load_mem, load_skid, advance;

  assign consume   = if_valid && !hazard_stall;
  assign out_free  = !if_valid || consume;
  assign rsp       = (state == WAIT) && imem_rvalid;
  // A response is dropped if it belongs to a squashed request or collides with a redirect.
  assign drop      = rsp && (squash || redirect);
  assign load_mem  = rsp && !drop && out_free;
  assign load_skid = (state == HOLD) && !redirect && consume;
  assign advance   = !rst && (load_mem || load_skid);

  assign imem_req    = !rst && (state == REQ);
  assign imem_addr   = pc;
  assign pc_stall    = rst || !(advance || redirect);
  assign pc_branch   = !rst && redirect;
  assign pc_branchpc = redirect_pc;
  assign if_pc       = out_q.pc;
  assign if_instr    = out_q.instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      squash   <= 1'b0;
      if_valid <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      if (redirect)                  if_valid <= 1'b0;
      else if (load_mem || load_skid) if_valid <= 1'b1;
      else if (consume)              if_valid <= 1'b0;

      if (load_mem)       out_q <= '{pc: pc, instr: imem_rdata};
      else if (load_skid) out_q <= skid_q;

      case (state)
        IDLE: state <= REQ;
        REQ: begin
          // A redirect during the accepted request makes its response stale.
          if (imem_ready) begin
            state  <= WAIT;
            squash <= redirect;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            squash <= 1'b0;
            if (drop || out_free) begin
              state <= REQ;
            end else begin
              state  <= HOLD;
              skid_q <= '{pc: pc, instr: imem_rdata};
            end
          end else if (redirect) begin
            squash <= 1'b1;
          end
        end
        HOLD: if (redirect || consume) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubbles <= '0;
      perf_squash  <= '0;
    end else begin
      if (!if_valid) perf_bubbles <= perf_bubbles + 32'd1;
      if (drop)      perf_squash  <= perf_squash + 32'd1;
    end
  end
`endif

endmodule
